cb_prog_loader: RTL and testbench

Serial configuration loader for the connection-block / CLB programming chain. It accepts the bitstream as parallel words over a valid/ready stream and shifts it LSB-first onto the chain's `prog_in`/`prog_en` pins, one bit per `prog_clk`. It sits between the configuration source (host bridge or config ROM) and the head of the chain, whose tail `prog_out` feeds back into this block.

---
 rtl/cb_prog_pkg.sv | 25 ++
 rtl/cb_prog_loader_if.sv | 11 +
 rtl/cb_prog_crc16.sv | 38 +++
 rtl/cb_prog_loader.sv | 147 ++++++++++++++
 tb/tb_cb_prog_loader.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cb_prog_pkg.sv
// Shared types and constants for the configuration-chain loader.
package cb_prog_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic int num_words(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // One MSB-first CRC-16-CCITT step for a single serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cb_prog_loader_if.sv
// Bitstream word stream (valid/ready) from the configuration source to the loader.
interface cb_prog_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/cb_prog_crc16.sv
// Bit-serial CRC-16-CCITT accumulator; only used when CB_PROG_READBACK_EN is defined.
module cb_prog_crc16
  import cb_prog_pkg::*;
(
  input  logic        prog_clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  // Init wins over folding a bit in.
  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc16_step(crc_q, bit_i);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register.
  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/cb_prog_loader.sv
// Word-to-serial loader for the CB/CLB programming chain, LSB first.
// Optional readback CRC check of the previous chain contents under CB_PROG_READBACK_EN.
module cb_prog_loader
  import cb_prog_pkg::*;
#(
  parameter int CHAIN_LEN = 69,
  parameter int WORD_W    = 32
) (
  input  logic                prog_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  cb_prog_loader_if.slave     s_if,
  output logic                prog_in,
  output logic                prog_en,
  input  logic                prog_out,
  output logic                busy,
  output logic                done,
  input  logic [15:0]         exp_crc,
  output logic                crc_err
);

  localparam int TOT_W = $clog2(CHAIN_LEN + 1);
  localparam int WRD_W = $clog2(WORD_W + 1);
  localparam logic [TOT_W-1:0] TOT_LAST = TOT_W'(CHAIN_LEN);
  localparam logic [WRD_W-1:0] WRD_LAST = WRD_W'(WORD_W);

  state_e            state_q, state_d;
  logic [TOT_W-1:0]  tot_cnt_q, tot_cnt_d, tot_inc_s;
  logic [WRD_W-1:0]  wrd_cnt_q, wrd_cnt_d, wrd_inc_s;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              prog_en_q, s_ready_q, busy_q, done_q;

  assign tot_inc_s = tot_cnt_q + TOT_W'(1);
  assign wrd_inc_s = wrd_cnt_q + WRD_W'(1);

  // Next state; abort beats start and a simultaneous word accept.
  always_comb begin
    state_d   = state_q;
    tot_cnt_d = tot_cnt_q;
    wrd_cnt_d = wrd_cnt_q;
    sreg_d    = sreg_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = LOAD;
            tot_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          if (s_if.s_valid && s_ready_q) begin
            state_d   = SHIFT;
            sreg_d    = s_if.s_data;
            wrd_cnt_d = '0;
          end else begin
            state_d = LOAD;
          end
        end
        SHIFT: begin
          sreg_d    = sreg_q >> 1'b1;
          tot_cnt_d = tot_inc_s;
          wrd_cnt_d = wrd_inc_s;
          // Final word: leftover upper bits are never shifted out.
          if (tot_inc_s == TOT_LAST) begin
            state_d = DONE;
          end else if (wrd_inc_s == WRD_LAST) begin
            state_d = LOAD;
          end else begin
            state_d = SHIFT;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath and flop-driven outputs decoded from the next state.
  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tot_cnt_q <= '0;
      wrd_cnt_q <= '0;
      sreg_q    <= '0;
      prog_en_q <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tot_cnt_q <= tot_cnt_d;
      wrd_cnt_q <= wrd_cnt_d;
      sreg_q    <= sreg_d;
      prog_en_q <= (state_d == SHIFT);
      s_ready_q <= (state_d == LOAD);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign prog_in     = sreg_q[0];
  assign prog_en     = prog_en_q;
  assign s_if.s_ready = s_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef CB_PROG_READBACK_EN
  logic [15:0] crc_s, exp_q;
  logic        crc_err_q, crc_init_s;

  assign crc_init_s = (state_q == IDLE) && start && !abort;

  cb_prog_crc16 u_crc (
    .prog_clk (prog_clk),
    .rst      (rst),
    .init_i   (crc_init_s),
    .en_i     (state_q == SHIFT),
    .bit_i    (prog_out),
    .crc_o    (crc_s)
  );

  // Capture expected CRC on start; compare once the load completes.
  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      exp_q     <= 16'h0000;
      crc_err_q <= 1'b0;
    end else if (crc_init_s) begin
      exp_q     <= exp_crc;
      crc_err_q <= 1'b0;
    end else if ((state_q == DONE) && !abort) begin
      crc_err_q <= (crc_s != exp_q);
    end
  end

  assign crc_err = crc_err_q;
`else
  logic unused_s;
  assign unused_s = ^{exp_crc, prog_out};
  assign crc_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cb_prog_loader.sv
// Directed bench for cb_prog_loader (69/32 main instance, 64/32 edge instance).
module tb_cb_prog_loader;

  logic        prog_clk, rst, start, abort, prog_in, prog_en, prog_out, busy, done, crc_err;
  logic [15:0] exp_crc;
  logic        start2, prog_in2, prog_en2, busy2, done2, crc_err2;

  cb_prog_loader_if #(.WORD_W(32)) s_if ();
  cb_prog_loader_if #(.WORD_W(32)) s_if2 ();

  cb_prog_loader #(.CHAIN_LEN(69), .WORD_W(32)) dut (
    .prog_clk(prog_clk), .rst(rst), .start(start), .abort(abort), .s_if(s_if),
    .prog_in(prog_in), .prog_en(prog_en), .prog_out(prog_out), .busy(busy),
    .done(done), .exp_crc(exp_crc), .crc_err(crc_err)
  );

  cb_prog_loader #(.CHAIN_LEN(64), .WORD_W(32)) dut2 (
    .prog_clk(prog_clk), .rst(rst), .start(start2), .abort(1'b0), .s_if(s_if2),
    .prog_in(prog_in2), .prog_en(prog_en2), .prog_out(1'b0), .busy(busy2),
    .done(done2), .exp_crc(16'h0000), .crc_err(crc_err2)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Reference chain: head takes prog_in, tail drives prog_out.
  logic [68:0] chain = '0;
  always @(posedge prog_clk) if (prog_en) chain <= {prog_in, chain[68:1]};
  assign prog_out = chain[0];

  int checks = 0;
  int failures = 0;
  int r_done_at, r_n_done, r_n_en, r_stall_n, r_stall_bad, r_abort_cyc;
  logic [68:0] r_seq;
  logic [3:0]  r_post;
  logic [5:0]  r_post_rst;

  localparam logic [95:0] PAT_A = {32'h0000001F, 32'h12345678, 32'hDEADBEEF};
  localparam logic [95:0] PAT_B = {32'hFFFFFFEA, 32'hA5A5A5A5, 32'h0F0F0F0F};
  localparam logic [68:0] SEQ_A = 69'h1F12345678DEADBEEF;
  localparam logic [68:0] SEQ_B = 69'h0AA5A5A5A50F0F0F0F;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [68:0] d);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < 69; i++) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // One load on the main instance; cycle 1 is the cycle after the start edge.
  task automatic run_load(input logic [95:0] bits, input int stall, input int abort_at,
                          input int rst_at, input int start_at, input logic [15:0] expc);
    int w, stall_left;
    w = 0; stall_left = stall;
    r_done_at = 0; r_n_done = 0; r_n_en = 0; r_seq = '0; r_stall_bad = 0;
    r_abort_cyc = 0; r_post = 4'hF; r_post_rst = 6'h3F;
    @(negedge prog_clk);
    start = 1'b1; exp_crc = expc; s_if.s_valid = 1'b1; s_if.s_data = bits[31:0];
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge prog_clk);
      start = 1'b0; abort = 1'b0;
      if (done) begin r_n_done++; r_done_at = cyc; end
      if (prog_en) begin
        if (r_n_en < 69) r_seq[r_n_en] = prog_in;
        r_n_en++;
      end
      if (r_abort_cyc > 0 && cyc == r_abort_cyc + 1) r_post = {prog_en, busy, s_if.s_ready, done};
      if (!busy && cyc > 1) break;
      if (rst_at > 0 && prog_en && r_n_en == rst_at) begin
        rst = 1'b0;
        #1;
        r_post_rst = {prog_in, prog_en, s_if.s_ready, busy, done, crc_err};
        @(negedge prog_clk);
        @(negedge prog_clk);
        rst = 1'b1;
        break;
      end
      if (abort_at > 0 && prog_en && r_n_en == abort_at) begin abort = 1'b1; r_abort_cyc = cyc; end
      if (start_at > 0 && prog_en && r_n_en == start_at) start = 1'b1;
      if (w < 3) s_if.s_data = bits[w*32 +: 32];
      if (w == 1 && stall_left > 0 && s_if.s_ready) begin
        stall_left--;
        s_if.s_valid = 1'b0;
        if (prog_en) r_stall_bad++;
      end else begin
        s_if.s_valid = 1'b1;
      end
      if (s_if.s_ready && s_if.s_valid) w++;
    end
    r_stall_n = stall - stall_left;
    s_if.s_valid = 1'b0;
  endtask

  initial begin
    int d2, n2, acc2, w2;
    logic [63:0] seq2;
    logic [63:0] pat2;
    rst = 1'b0; start = 1'b0; abort = 1'b0; exp_crc = 16'h0000;
    s_if.s_valid = 1'b0; s_if.s_data = 32'h0;
    start2 = 1'b0; s_if2.s_valid = 1'b0; s_if2.s_data = 32'h0;
    #2;
    chk("reset_outputs", {prog_in, prog_en, s_if.s_ready, busy, done, crc_err}, 6'b000000);
    @(negedge prog_clk);
    @(negedge prog_clk);
    rst = 1'b1;

    run_load(PAT_A, 0, 0, 0, 0, 16'h0000);
    chk("basic_done_cycle", r_done_at, 73);
    chk("basic_done_count", r_n_done, 1);
    chk("basic_en_cycles", r_n_en, 69);
    chk("basic_sequence", r_seq, SEQ_A);
    chk("basic_chain", chain, SEQ_A);

    run_load(PAT_A, 5, 0, 0, 0, 16'h0000);
    chk("stall_done_cycle", r_done_at, 78);
    chk("stall_cycles", r_stall_n, 5);
    chk("stall_prog_en", r_stall_bad, 0);
    chk("stall_sequence", r_seq, SEQ_A);
    chk("stall_chain", chain, SEQ_A);

    run_load(PAT_B, 0, 40, 0, 0, 16'h0000);
    chk("abort_next_cycle", r_post, 4'b0000);
    chk("abort_no_done", r_n_done, 0);
    chk("abort_bits", r_n_en, 40);

    run_load(PAT_B, 0, 0, 0, 0, 16'h0000);
    chk("after_abort_done", r_done_at, 73);
    chk("after_abort_sequence", r_seq, SEQ_B);
    chk("after_abort_chain", chain, SEQ_B);

    run_load(PAT_A, 0, 0, 36, 0, 16'h0000);
    chk("reset_mid_outputs", r_post_rst, 6'b000000);
    run_load(PAT_A, 0, 0, 0, 0, 16'h0000);
    chk("after_reset_done", r_done_at, 73);
    chk("after_reset_sequence", r_seq, SEQ_A);
    chk("after_reset_chain", chain, SEQ_A);

    run_load(PAT_A, 0, 0, 0, 10, 16'h0000);
    chk("ign_start_done", r_done_at, 73);
    chk("ign_start_count", r_n_done, 1);
    chk("ign_start_sequence", r_seq, SEQ_A);

    pat2 = 64'h01234567CAFEF00D;
    d2 = 0; n2 = 0; acc2 = 0; w2 = 0; seq2 = '0;
    @(negedge prog_clk);
    start2 = 1'b1; s_if2.s_valid = 1'b1; s_if2.s_data = pat2[31:0];
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge prog_clk);
      start2 = 1'b0;
      if (done2) d2 = cyc;
      if (prog_en2) begin
        if (n2 < 64) seq2[n2] = prog_in2;
        n2++;
      end
      if (!busy2 && cyc > 1) break;
      if (w2 < 2) s_if2.s_data = pat2[w2*32 +: 32];
      if (s_if2.s_ready && s_if2.s_valid) begin acc2++; w2++; end
    end
    s_if2.s_valid = 1'b0;
    chk("len64_done_cycle", d2, 67);
    chk("len64_en_cycles", n2, 64);
    chk("len64_words", acc2, 2);
    chk("len64_sequence", seq2, pat2);

`ifdef CB_PROG_READBACK_EN
    run_load(PAT_A, 0, 0, 0, 0, crc_model(SEQ_A));
    chk("readback_match", crc_err, 1'b0);
    run_load(PAT_A, 0, 0, 0, 0, crc_model(SEQ_A) ^ 16'h0001);
    chk("readback_mismatch", crc_err, 1'b1);
`else
    chk("crc_err_tied", {crc_err, crc_err2}, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
